// File: rtl/lrf_fuse_sequencer.sv
// rtl/lrf_fuse_sequencer.sv - frame-level job sequencer in front of the LRF fusion core
//
// Purpose: passes one job of N_FUSE_COUNT input frames straight through to the
// fusion core, regenerates tlast from a beat count, tags beats with a frame
// index, then waits for one fused output frame before pulsing done.
//
// Ports:
//   s_axis_aclk, s_axis_aresetn  clock, synchronous active-low reset
//   start, abort                 job control (abort has priority)
//   busy, done                   state != IDLE; one-cycle completion pulse
//   err_early, err_late          sticky upstream tlast framing errors
//   err_out                      sticky core output tlast framing error
//   s_axis_*                     upstream stream (tlast checked, not forwarded)
//   m_axis_*, m_frame_idx        stream to the core, zero-latency in RUN
//   cout_tvalid/tready/tlast     core output handshake, monitored only
module lrf_fuse_sequencer #(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int IMAGE_DIM       = 512,
  parameter int N_FUSE_COUNT    = 4,
  parameter int DATA_WIDTH      = 8 * PIXELS_PER_BEAT
) (
  input  logic                            s_axis_aclk,
  input  logic                            s_axis_aresetn,
  input  logic                            start,
  input  logic                            abort,
  output logic                            busy,
  output logic                            done,
  output logic                            err_early,
  output logic                            err_late,
  output logic                            err_out,
  input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [$clog2(N_FUSE_COUNT)-1:0] m_frame_idx,
  input  logic                            cout_tvalid,
  input  logic                            cout_tready,
  input  logic                            cout_tlast
);

  localparam int BPF = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT;
  localparam int CW  = $clog2(BPF);
  localparam int FW  = $clog2(N_FUSE_COUNT);
  localparam logic [CW-1:0] LAST_BEAT  = CW'(BPF - 1);
  localparam logic [FW-1:0] LAST_FRAME = FW'(N_FUSE_COUNT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] in_cnt;
  logic [CW-1:0] out_cnt;
  logic [FW-1:0] frame_idx;
  logic          out_done;

  logic run;
  logic mon;
  logic in_last;
  logic ihs;
  logic ohs;
  logic out_complete;
  logic in_final;

  assign run     = (state == RUN);
  assign mon     = (state == RUN) || (state == DRAIN);
  assign in_last = (in_cnt == LAST_BEAT);

  // Zero-latency pass-through while RUN; everything is closed off otherwise.
  assign s_axis_tready = run & m_axis_tready;
  assign m_axis_tvalid = run & s_axis_tvalid;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tlast  = run & in_last;
  assign m_frame_idx   = frame_idx;

  assign ihs = s_axis_tvalid & s_axis_tready;
  // Output beats only count while monitoring and until the fused frame is complete.
  assign ohs          = mon & cout_tvalid & cout_tready & ~out_done;
  assign out_complete = ohs & (out_cnt == LAST_BEAT);
  assign in_final     = ihs & in_last & (frame_idx == LAST_FRAME);

  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      frame_idx <= '0;
      out_done  <= 1'b0;
      err_early <= 1'b0;
      err_late  <= 1'b0;
      err_out   <= 1'b0;
    end else if (abort) begin
      // Error flags survive an abort so software can still inspect them.
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      frame_idx <= '0;
      out_done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            in_cnt    <= '0;
            out_cnt   <= '0;
            frame_idx <= '0;
            out_done  <= 1'b0;
            err_early <= 1'b0;
            err_late  <= 1'b0;
            err_out   <= 1'b0;
          end
        end
        RUN: begin
          if (ihs) begin
            if (s_axis_tlast && !in_last) err_early <= 1'b1;
            if (!s_axis_tlast && in_last) err_late <= 1'b1;
            // Framing follows the beat count regardless of upstream tlast.
            if (in_last) begin
              in_cnt    <= '0;
              frame_idx <= frame_idx + 1'b1;
            end else begin
              in_cnt <= in_cnt + 1'b1;
            end
            if (in_final) begin
              // Skip DRAIN when the fused frame already finished (or finishes now).
              if (out_done || out_complete) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= DRAIN;
              end
            end
          end
        end
        DRAIN: begin
          if (out_done || out_complete) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (ohs) begin
        if (cout_tlast != (out_cnt == LAST_BEAT)) err_out <= 1'b1;
        // Hold out_cnt on the final beat; out_done then masks further beats.
        if (out_cnt == LAST_BEAT) out_done <= 1'b1;
        else                      out_cnt  <= out_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lrf_fuse_sequencer.sv
// tb/tb_lrf_fuse_sequencer.sv - randomized self-checking bench for lrf_fuse_sequencer
module tb_lrf_fuse_sequencer;

  localparam int PPB   = 16;
  localparam int DIM   = 8;
  localparam int NF    = 4;
  localparam int DW    = 8 * PPB;
  localparam int BPF   = DIM * DIM / PPB;
  localparam int TOTAL = NF * BPF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn, start, abort;
  logic          busy, done, err_early, err_late, err_out;
  logic [DW-1:0] s_tdata, m_tdata;
  logic          s_tvalid, s_tready, s_tlast;
  logic          m_tvalid, m_tready, m_tlast;
  logic [1:0]    m_frame_idx;
  logic          cout_tvalid, cout_tready, cout_tlast;

  lrf_fuse_sequencer #(
    .PIXELS_PER_BEAT(PPB),
    .IMAGE_DIM      (DIM),
    .N_FUSE_COUNT   (NF),
    .DATA_WIDTH     (DW)
  ) dut (
    .s_axis_aclk   (clk),
    .s_axis_aresetn(rstn),
    .start         (start),
    .abort         (abort),
    .busy          (busy),
    .done          (done),
    .err_early     (err_early),
    .err_late      (err_late),
    .err_out       (err_out),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .m_frame_idx   (m_frame_idx),
    .cout_tvalid   (cout_tvalid),
    .cout_tready   (cout_tready),
    .cout_tlast    (cout_tlast)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Job-level reference: how many beats went in and came out, plus sticky flags.
  bit mdl_active, mdl_done, mdl_ee, mdl_el, mdl_eo;
  int mdl_in, mdl_out;

  // Stimulus knobs for the current job.
  int k_pv = 100, k_pr = 100, k_po = 0, k_tlast_mode = 0;
  bit k_out_early = 1'b0, k_bad_cout = 1'b0;

  task automatic step(input bit do_start, input bit do_abort, input bit do_rst);
    bit accepting, ihs, ohs;
    rstn  = !do_rst;
    start = do_start;
    abort = do_abort;
    accepting = mdl_active && !mdl_done && (mdl_in < TOTAL);
    s_tvalid = ($urandom_range(99) < k_pv);
    s_tdata  = {$urandom, $urandom, $urandom, $urandom};
    s_tlast  = ((mdl_in % BPF) == BPF - 1);
    if (k_tlast_mode == 1 && $urandom_range(9) == 0) s_tlast = !s_tlast;
    if (k_tlast_mode == 2 && (mdl_in == 1 || mdl_in == 3)) s_tlast = !s_tlast;
    m_tready    = ($urandom_range(99) < k_pr);
    cout_tvalid = ($urandom_range(99) < k_po) && (k_out_early || mdl_in == TOTAL);
    cout_tready = ($urandom_range(3) != 0);
    cout_tlast  = (mdl_out == BPF - 1);
    if (k_bad_cout && mdl_out == 2) cout_tlast = 1'b1;

    @(negedge clk);
    check_eq("busy",      DW'(busy),      DW'(mdl_active));
    check_eq("done",      DW'(done),      DW'(mdl_done));
    check_eq("err_early", DW'(err_early), DW'(mdl_ee));
    check_eq("err_late",  DW'(err_late),  DW'(mdl_el));
    check_eq("err_out",   DW'(err_out),   DW'(mdl_eo));
    check_eq("s_tready",  DW'(s_tready),  DW'(accepting && m_tready));
    check_eq("m_tvalid",  DW'(m_tvalid),  DW'(accepting && s_tvalid));
    check_eq("m_tlast",   DW'(m_tlast),   DW'(accepting && ((mdl_in % BPF) == BPF - 1)));
    if (accepting) check_eq("frame_idx", DW'(m_frame_idx), DW'(mdl_in / BPF));
    if (accepting && s_tvalid) check_eq("m_tdata", m_tdata, s_tdata);

    ihs = accepting && s_tvalid && m_tready;
    ohs = cout_tvalid && cout_tready;
    if (do_rst) begin
      mdl_active = 0; mdl_done = 0; mdl_in = 0; mdl_out = 0;
      mdl_ee = 0; mdl_el = 0; mdl_eo = 0;
    end else if (do_abort && mdl_active) begin
      mdl_active = 0; mdl_done = 0; mdl_in = 0; mdl_out = 0;
    end else if (!mdl_active) begin
      if (do_start && !do_abort) begin
        mdl_active = 1; mdl_in = 0; mdl_out = 0;
        mdl_ee = 0; mdl_el = 0; mdl_eo = 0;
      end
    end else if (mdl_done) begin
      mdl_active = 0; mdl_done = 0;
    end else begin
      if (ohs && mdl_out < BPF) begin
        if (cout_tlast != (mdl_out == BPF - 1)) mdl_eo = 1;
        mdl_out++;
      end
      if (ihs) begin
        if (s_tlast && (mdl_in % BPF) != BPF - 1) mdl_ee = 1;
        if (!s_tlast && (mdl_in % BPF) == BPF - 1) mdl_el = 1;
        mdl_in++;
      end
      if (mdl_in == TOTAL && mdl_out == BPF) mdl_done = 1;
    end

    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int pv, input int pr, input int po, input bit out_early,
                         input int tmode, input bit bad_cout, input int abort_at,
                         input bit rst_drain, input bit start_noise, input bit dual_start);
    int cyc;
    bit ab, rs, st;
    k_pv = pv; k_pr = pr; k_po = po; k_out_early = out_early;
    k_tlast_mode = tmode; k_bad_cout = bad_cout;
    if (dual_start) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    cyc = 0;
    while (mdl_active && cyc < 3000) begin
      ab = (abort_at >= 0) && (mdl_in == abort_at);
      rs = rst_drain && (mdl_in == TOTAL) && !mdl_done && (mdl_out < BPF);
      st = start_noise && ($urandom_range(4) == 0);
      step(st, ab, rs);
      cyc++;
    end
    check_eq("job_ends", DW'(cyc < 3000), DW'(1));
    k_po = 50; k_out_early = 1'b1;
    repeat (3) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rstn = 0; start = 0; abort = 0;
    s_tdata = '0; s_tvalid = 0; s_tlast = 0; m_tready = 0;
    cout_tvalid = 0; cout_tready = 0; cout_tlast = 0;
    repeat (2) @(posedge clk);
    #1;
    mdl_active = 0; mdl_done = 0; mdl_in = 0; mdl_out = 0;
    mdl_ee = 0; mdl_el = 0; mdl_eo = 0;
    repeat (2) step(1'b0, 1'b0, 1'b0);

    // clean job, output returned after input ends
    run_job(100, 100, 100, 1'b0, 0, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    // backpressure with start pulses while busy
    run_job(60, 50, 50, 1'b1, 0, 1'b0, -1, 1'b0, 1'b1, 1'b0);
    // early tlast on beat 1, missing tlast on beat 3
    run_job(100, 100, 70, 1'b0, 2, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    // fused frame finishes while input still running
    run_job(50, 100, 100, 1'b1, 0, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    // core tlast on output beat 2
    run_job(80, 80, 80, 1'b1, 0, 1'b1, -1, 1'b0, 1'b0, 1'b0);
    // start+abort together in IDLE, then abort after six input beats
    run_job(100, 100, 50, 1'b0, 0, 1'b0, 6, 1'b0, 1'b0, 1'b1);
    // clean job after the abort
    run_job(100, 100, 100, 1'b0, 0, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    // reset while draining
    run_job(100, 100, 50, 1'b0, 0, 1'b0, -1, 1'b1, 1'b0, 1'b0);
    // random jobs
    for (int j = 0; j < 10; j++) begin
      run_job($urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(20, 100),
              1'($urandom_range(1)), 1, 1'($urandom_range(1)), -1, 1'b0,
              1'($urandom_range(1)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lrf_fuse_sequencer.md
Name: lrf_fuse_sequencer

Overview:
- Frame-level controller in front of the LRF fusion core.
- Accepts one job of N_FUSE_COUNT input frames on an AXI-Stream slave and forwards them to the core with zero latency. Regenerates tlast from a beat count and tags each beat with its frame index.
- After the last input beat, blocks further input and waits for one full fused output frame from the core. Then it signals done.
- Reports framing errors on the input and output streams.

Parameters:
- PIXELS_PER_BEAT, 16, pixels per stream beat.
- IMAGE_DIM, 512, frame width and height in pixels.
- N_FUSE_COUNT, 4, input frames per fusion job (≥2).
- DATA_WIDTH, 8*PIXELS_PER_BEAT, stream data width.
- Local BPF = IMAGE_DIM*IMAGE_DIM/PIXELS_PER_BEAT, beats per frame (must be an integer ≥2).

Ports:
- s_axis_aclk  in  1  clock.
- s_axis_aresetn  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle job start request.
- abort  in  1  synchronous job abort.
- busy  out  1  high when the state is not IDLE.
- done  out  1  one-cycle pulse when a job completes.
- err_early  out  1  sticky: upstream tlast arrived before beat BPF-1.
- err_late  out  1  sticky: upstream tlast missing on beat BPF-1.
- err_out  out  1  sticky: core tlast does not match its output beat count.
- s_axis_tdata  in  DATA_WIDTH  upstream data.
- s_axis_tvalid  in  1  upstream valid.
- s_axis_tready  out  1  upstream ready.
- s_axis_tlast  in  1  upstream tlast; checked only, never forwarded.
- m_axis_tdata  out  DATA_WIDTH  data to the core.
- m_axis_tvalid  out  1  valid to the core.
- m_axis_tready  in  1  ready from the core.
- m_axis_tlast  out  1  regenerated end-of-frame.
- m_frame_idx  out  clog2(N_FUSE_COUNT)  index of the current input frame.
- cout_tvalid  in  1  core output valid; monitor only.
- cout_tready  in  1  core output ready; monitor only.
- cout_tlast  in  1  core output tlast; monitor only.

Behaviour:
- Reset (s_axis_aresetn=0 at a clock edge):
  - state=IDLE; in_cnt, out_cnt, frame_idx and out_done cleared to 0.
  - busy=0, done=0, and all error flags 0.
  - s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0.
  - Reset mid-job discards the job with no done pulse.
- Handshakes:
  - In-handshake (ihs) = s_axis_tvalid & s_axis_tready.
  - Out-handshake (ohs) = cout_tvalid & cout_tready.
- IDLE:
  - s_axis_tready=0 and m_axis_tvalid=0.
  - start=1 → RUN. The same edge clears in_cnt, out_cnt, frame_idx, out_done and all error flags.
- RUN (combinational pass-through, 0-cycle latency):
  - m_axis_tdata=s_axis_tdata, m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready.
  - m_axis_tlast=(in_cnt==BPF-1); m_frame_idx=frame_idx.
  - On ihs: in_cnt++. At BPF-1, in_cnt wraps to 0 and frame_idx++.
  - On ihs with frame_idx==N_FUSE_COUNT-1 and in_cnt==BPF-1:
    - next state is DONE if out_done=1 or this beat's ohs completes the output frame;
    - otherwise next state is DRAIN.
  - Error checks on ihs:
    - s_axis_tlast=1 with in_cnt≠BPF-1 → err_early=1.
    - s_axis_tlast=0 with in_cnt==BPF-1 → err_late=1.
    - Framing always follows the beat count.
- Output monitor (active in RUN and DRAIN):
  - On ohs: out_cnt++.
  - cout_tlast≠(out_cnt==BPF-1) → err_out=1.
  - ohs at out_cnt==BPF-1 sets out_done=1 and holds out_cnt.
  - Further ohs after out_done are ignored.
- DRAIN:
  - s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0.
  - out_done=1, or ohs completing the output frame → DONE.
- DONE:
  - done=1 for exactly this one cycle; next state IDLE.
  - Stream outputs behave as in DRAIN.
- start while busy: ignored.
- abort=1 in RUN, DRAIN or DONE:
  - next state IDLE; counters cleared; no done pulse.
  - Error flags are held until the next accepted start.
  - abort has priority over all transitions.
- start and abort together in IDLE: abort wins and the state stays IDLE.
- busy=(state≠IDLE), registered together with the state.
- Counter widths: in_cnt and out_cnt are clog2(BPF) bits. There is no other arithmetic.

Test Plan:
- Bench setup: IMAGE_DIM=8, PIXELS_PER_BEAT=16 (BPF=4), N_FUSE_COUNT=4.
- Clean job: start; 16 input beats with correct tlast, m_axis_tready=1; core returns 4 beats after input ends → m_axis_tlast on beats 3,7,11,15; m_frame_idx 0..3; s_axis_tready=0 after beat 15; done pulse 1 cycle after the 4th ohs; no error flags.
- Backpressure: random m_axis_tready and s_axis_tvalid → s_axis_tready mirrors m_axis_tready in RUN; exactly 16 ihs; data matches in order.
- Early and late tlast: upstream tlast on beat 1 and missing on beat 3 → err_early=1 and err_late=1; the regenerated tlast is still on beats 3,7,11,15; job completes with done.
- Output during RUN: core emits all 4 output beats before input beat 15 → out_done set; on the final ihs the state goes straight to DONE; done 1 cycle later; DRAIN is skipped.
- Output framing error: cout_tlast on output beat 2 → err_out=1; job still completes.
- Abort, reset and start-while-busy:
  - abort after input beat 6 → busy=0 next cycle; no done pulse; a new start runs cleanly from frame_idx=0.
  - Reset mid-DRAIN → all outputs return to reset values.
  - start during RUN → no effect.
